pdp_mem_responder: RTL and testbench

Word-addressed 4096 x 12-bit main memory that serves the multicycle controller's read and write requests. It adds a programmable number of wait states and signals completion with a one-cycle ready pulse. It optionally implements PDP-8 auto-index semantics: indirect fetches through locations 0o10–0o17 pre-increment the stored pointer. It sits between the datapath's address mux (PC/EA) and the IR/data registers.

---
 rtl/pdp_mem_responder.sv | 134 +++++++++++++
 tb/tb_pdp_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_mem_responder.sv
// 4096x12 word memory responder with programmable wait states and a one-cycle ready pulse.
// Define MEM_AUTOINDEX_EN to enable PDP-8 auto-index pre-increment on indirect fetches via 0o10-0o17.
module pdp_mem_responder #(
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = 12,
  parameter int unsigned WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic          indirect,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          busy
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;

`ifdef MEM_AUTOINDEX_EN
  typedef enum logic [2:0] {IDLE, WAIT_ST, ACCESS, AUTOINC, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_ST, ACCESS, RESP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic          auto_idx;

`ifdef MEM_AUTOINDEX_EN
  logic          ind_q;
  assign auto_idx = ind_q && !we_q && (addr_q[AW-1:3] == (AW-3)'(1));
`else
  logic          unused_indirect;
  assign unused_indirect = indirect;
  assign auto_idx        = 1'b0;
`endif

  // Memory port: the write commits at the edge that ends ACCESS or AUTOINC.
  always_comb begin
    mem_we = 1'b0;
    mem_wd = wdata_q;
    if (state == ACCESS && we_q) mem_we = 1'b1;
`ifdef MEM_AUTOINDEX_EN
    if (state == AUTOINC) begin
      mem_we = 1'b1;
      mem_wd = rdata + DW'(1);
    end
`endif
  end

  // The array has no reset; writes are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[addr_q] <= mem_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
`ifdef MEM_AUTOINDEX_EN
      ind_q   <= 1'b0;
`endif
      rdata   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
`ifdef MEM_AUTOINDEX_EN
            ind_q   <= indirect;
`endif
            cnt     <= CW'(WAIT);
            busy    <= 1'b1;
            state   <= (WAIT > 0) ? WAIT_ST : ACCESS;
          end
        end
        WAIT_ST: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ACCESS;
        end
        ACCESS: begin
          if (we_q) begin
            state <= RESP;
            ready <= 1'b1;
          end else begin
            rdata <= mem[addr_q];
            if (auto_idx) begin
`ifdef MEM_AUTOINDEX_EN
              state <= AUTOINC;
`endif
            end else begin
              state <= RESP;
              ready <= 1'b1;
            end
          end
        end
`ifdef MEM_AUTOINDEX_EN
        AUTOINC: begin
          rdata <= rdata + DW'(1);
          state <= RESP;
          ready <= 1'b1;
        end
`endif
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp_mem_responder.sv
// Bench for pdp_mem_responder: three instances (WAIT=0,2,3) checked every cycle against a
// transaction-level model of latency, busy window and read data, plus literal spot checks.
module tb_pdp_mem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst, req, we, ind, ready, busy;
  logic [11:0] addr  [3];
  logic [11:0] wdata [3];
  logic [11:0] rdata [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state
  logic [11:0] mm [3][4096];
  logic [11:0] last_rd [3];
  bit          exp_ready [int];
  bit          exp_busy  [int];
  logic [11:0] exp_rd    [int];
  int          ready_cnt [3];
  int          last_ready [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pdp_mem_responder #(.AW(12), .DW(12), .WAIT(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clk(clk), .rst(rst[g]), .req(req[g]), .we(we[g]), .indirect(ind[g]),
      .addr(addr[g]), .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]), .busy(busy[g])
    );
  end

  function automatic int wait_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  task automatic check(string nm, int i, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d: got %o want %o", nm, i, cyc, act, exp);
    end
  endtask

  // Transaction model: latency from the rules, memory as a plain array.
  function automatic int add_txn(int i, int t0, bit w, bit ix, logic [11:0] a, logic [11:0] d);
    bit ai;
    int lat;
    logic [11:0] v;
    ai = 1'b0;
`ifdef MEM_AUTOINDEX_EN
    ai = ix && !w && (a >= 12'o0010) && (a <= 12'o0017);
`else
    ai = ix && 1'b0;
`endif
    lat = wait_of(i) + 2 + (ai ? 1 : 0);
    if (w) mm[i][a] = d;
    else begin
      v = mm[i][a];
      if (ai) begin
        v = v + 12'd1;
        mm[i][a] = v;
      end
      last_rd[i] = v;
    end
    for (int c = 1; c <= lat; c++) exp_busy[(t0 + c) * 4 + i] = 1'b1;
    exp_ready[(t0 + lat) * 4 + i] = 1'b1;
    exp_rd[(t0 + lat) * 4 + i] = last_rd[i];
    return lat;
  endfunction

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    int key;
    bit er, eb;
    for (int i = 0; i < 3; i++) begin
      key = cyc * 4 + i;
      er = exp_ready.exists(key);
      eb = exp_busy.exists(key);
      check("ready", i, int'(ready[i]), int'(er));
      check("busy", i, int'(busy[i]), int'(eb));
      if (er) check("rdata", i, int'(rdata[i]), int'(exp_rd[key]));
      if (ready[i]) begin
        ready_cnt[i]++;
        last_ready[i] = cyc;
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // One request; tog wiggles req/addr while the access is in flight.
  task automatic go(int i, bit w, bit ix, logic [11:0] a, logic [11:0] d, bit tog, output int t0);
    int lat;
    at_neg();
    req[i] = 1'b1; we[i] = w; ind[i] = ix; addr[i] = a; wdata[i] = d;
    t0 = cyc;
    lat = add_txn(i, t0, w, ix, a, d);
    for (int k = 1; k <= lat; k++) begin
      at_neg();
      req[i]   = (tog && k < lat) ? k[0] : 1'b0;
      we[i]    = 1'($urandom);
      ind[i]   = 1'($urandom);
      addr[i]  = 12'($urandom);
      wdata[i] = 12'($urandom);
    end
    at_neg();
  endtask

  initial begin
    int t0, n0;
    int alat;
    logic [11:0] ai_val, ai_wrap;
`ifdef MEM_AUTOINDEX_EN
    alat = 5; ai_val = 12'o0500; ai_wrap = 12'o0000;
`else
    alat = 4; ai_val = 12'o0477; ai_wrap = 12'o7777;
`endif
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdata[i] = '0; last_rd[i] = '0; ready_cnt[i] = 0; last_ready[i] = 0;
    end
    rst = 3'b111; req = '0; we = '0; ind = '0;
    repeat (3) at_neg();
    for (int i = 0; i < 3; i++) begin
      check("rst_rdata", i, int'(rdata[i]), 0);
      check("rst_ready", i, int'(ready[i]), 0);
      check("rst_busy", i, int'(busy[i]), 0);
    end
    rst = 3'b000;
    at_neg();

    // WAIT=2 write then read
    go(1, 1'b1, 1'b0, 12'o0100, 12'o1234, 1'b0, t0);
    check("wr_lat_w2", 1, last_ready[1] - t0, 4);
    go(1, 1'b0, 1'b0, 12'o0100, 12'o0000, 1'b0, t0);
    check("rd_lat_w2", 1, last_ready[1] - t0, 4);
    check("rd_val_w2", 1, int'(rdata[1]), 12'o1234);

    // WAIT=0 read, then req held past ready
    go(0, 1'b1, 1'b0, 12'o0005, 12'o7070, 1'b0, t0);
    go(0, 1'b0, 1'b0, 12'o0005, 12'o0000, 1'b0, t0);
    check("rd_lat_w0", 0, last_ready[0] - t0, 2);
    check("rd_val_w0", 0, int'(rdata[0]), 12'o7070);
    n0 = ready_cnt[0];
    at_neg();
    req[0] = 1'b1; we[0] = 1'b0; ind[0] = 1'b0; addr[0] = 12'o0005;
    t0 = cyc;
    void'(add_txn(0, t0, 1'b0, 1'b0, 12'o0005, 12'o0));
    void'(add_txn(0, t0 + 3, 1'b0, 1'b0, 12'o0005, 12'o0));
    repeat (4) at_neg();
    req[0] = 1'b0;
    repeat (3) at_neg();
    check("b2b_pulses", 0, ready_cnt[0] - n0, 2);
    check("b2b_second", 0, last_ready[0] - t0, 5);

    // auto-index pointer fetches
    go(1, 1'b1, 1'b0, 12'o0012, 12'o0477, 1'b0, t0);
    go(1, 1'b0, 1'b1, 12'o0012, 12'o0000, 1'b0, t0);
    check("ai_lat", 1, last_ready[1] - t0, alat);
    check("ai_val", 1, int'(rdata[1]), int'(ai_val));
    go(1, 1'b0, 1'b0, 12'o0012, 12'o0000, 1'b0, t0);
    check("ai_mem", 1, int'(rdata[1]), int'(ai_val));
    go(1, 1'b1, 1'b0, 12'o0012, 12'o7777, 1'b0, t0);
    go(1, 1'b0, 1'b1, 12'o0012, 12'o0000, 1'b0, t0);
    check("ai_wrap", 1, int'(rdata[1]), int'(ai_wrap));
    go(1, 1'b1, 1'b0, 12'o0017, 12'o0100, 1'b0, t0);
    go(1, 1'b0, 1'b1, 12'o0017, 12'o0000, 1'b0, t0);
    go(1, 1'b1, 1'b0, 12'o0020, 12'o3333, 1'b0, t0);
    go(1, 1'b0, 1'b1, 12'o0020, 12'o0000, 1'b0, t0);
    check("ind_noai_lat", 1, last_ready[1] - t0, 4);
    check("ind_noai_val", 1, int'(rdata[1]), 12'o3333);
    go(1, 1'b1, 1'b1, 12'o0011, 12'o0042, 1'b0, t0);
    go(1, 1'b0, 1'b0, 12'o0011, 12'o0000, 1'b0, t0);
    check("ind_write", 1, int'(rdata[1]), 12'o0042);
    go(1, 1'b1, 1'b0, 12'o7777, 12'o4321, 1'b0, t0);
    go(1, 1'b0, 1'b0, 12'o7777, 12'o0000, 1'b0, t0);
    check("top_addr", 1, int'(rdata[1]), 12'o4321);

    // WAIT=3: req/addr wiggled during WAIT_ST are ignored
    go(2, 1'b1, 1'b0, 12'o0300, 12'o2222, 1'b0, t0);
    n0 = ready_cnt[2];
    go(2, 1'b0, 1'b0, 12'o0300, 12'o0000, 1'b1, t0);
    check("tog_pulses", 2, ready_cnt[2] - n0, 1);
    check("tog_val", 2, int'(rdata[2]), 12'o2222);
    check("tog_lat", 2, last_ready[2] - t0, 5);

    // WAIT=3: reset in cycle 2 of a write loses it
    go(2, 1'b1, 1'b0, 12'o0200, 12'o1111, 1'b0, t0);
    at_neg();
    req[2] = 1'b1; we[2] = 1'b1; ind[2] = 1'b0; addr[2] = 12'o0200; wdata[2] = 12'o5555;
    t0 = cyc;
    void'(add_txn(2, t0, 1'b1, 1'b0, 12'o0200, 12'o5555));
    at_neg();
    req[2] = 1'b0;
    at_neg();
    rst[2] = 1'b1;
    #1;
    check("rst_mid_ready", 2, int'(ready[2]), 0);
    check("rst_mid_busy", 2, int'(busy[2]), 0);
    for (int c = cyc + 1; c < cyc + 16; c++) begin
      if (exp_ready.exists(c * 4 + 2)) exp_ready.delete(c * 4 + 2);
      if (exp_busy.exists(c * 4 + 2)) exp_busy.delete(c * 4 + 2);
    end
    mm[2][12'o0200] = 12'o1111;
    last_rd[2] = 12'o0000;
    at_neg();
    rst[2] = 1'b0;
    check("rst_mid_rdata", 2, int'(rdata[2]), 0);
    at_neg();
    go(2, 1'b0, 1'b0, 12'o0200, 12'o0000, 1'b0, t0);
    check("rst_lost_wr", 2, int'(rdata[2]), 12'o1111);

    repeat (3) at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
